// File: rtl/sc_microsequencer.sv
// sc_microsequencer: microcoded controller for a restoring subtract-loop
// divider datapath (repeated R1 - R0 into a quotient count).
// Optional feature macro: SC_MICROSEQUENCER_SHIFT_EN adds a shifter load
// and a quotient-length left-shift phase before DONE.
// All control outputs are registered: the next state is decoded into its
// control word, and that word is registered at the same edge as the state.
// SC_MICROSEQUENCER_state_OutBUS exposes the current state for debug.
module sc_microsequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 4,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter logic [7:0] MAX_ITER               = 8'd200
) (
  input  logic                                      SC_MICROSEQUENCER_CLOCK_50,
  input  logic                                      SC_MICROSEQUENCER_RESET_InHigh,
  input  logic                                      SC_MICROSEQUENCER_start_InHigh,
  input  logic                                      SC_MICROSEQUENCER_negative_InLow,
  input  logic                                      SC_MICROSEQUENCER_zero_InLow,
  input  logic                                      SC_MICROSEQUENCER_carry_InLow,
  input  logic                                      SC_MICROSEQUENCER_overflow_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQUENCER_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQUENCER_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQUENCER_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQUENCER_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MICROSEQUENCER_aluselection_OutBUS,
  output logic                                      SC_MICROSEQUENCER_regSHIFTERclear_OutLow,
  output logic                                      SC_MICROSEQUENCER_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS,
  output logic                                      SC_MICROSEQUENCER_busy_OutHigh,
  output logic                                      SC_MICROSEQUENCER_done_OutHigh,
  output logic                                      SC_MICROSEQUENCER_error_OutHigh,
  output logic [7:0]                                SC_MICROSEQUENCER_quotient_OutBUS,
  output logic [3:0]                                SC_MICROSEQUENCER_state_OutBUS
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_CLR = 4'd1, S_LDA = 4'd2, S_LDB = 4'd3,
    S_SUB = 4'd4, S_WAIT = 4'd5, S_CHK = 4'd6, S_RESTORE = 4'd7,
    S_SHLD = 4'd8, S_SHIFT = 4'd9, S_DONE = 4'd10, S_ERROR = 4'd11
  } state_t;

  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;
  localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;

  localparam logic [DW-1:0] DEC_NONE = '1;
  localparam logic [MW-1:0] MUX_R0   = MW'(0);
  localparam logic [MW-1:0] MUX_R1   = MW'(1);
  localparam logic [MW-1:0] MUX_FIX0 = MW'(4);
  localparam logic [MW-1:0] MUX_FIX1 = MW'(5);
  localparam logic [AW-1:0] ALU_ADD  = AW'(0);
  localparam logic [AW-1:0] ALU_SUB  = AW'(1);
  localparam logic [AW-1:0] ALU_PASS = AW'(2);
  localparam logic [SW-1:0] SH_HOLD  = SW'(0);
  localparam logic [SW-1:0] SH_LEFT  = SW'(1);

  state_t      state_q, state_d;
  logic [1:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  quot_q, quot_d;
`ifdef SC_MICROSEQUENCER_SHIFT_EN
  logic [7:0]  shcnt_q, shcnt_d;
`endif

  logic [DW-1:0] clr_sel_q, clr_sel_d, ld_sel_q, ld_sel_d;
  logic [MW-1:0] mux_a_q, mux_a_d, mux_b_q, mux_b_d;
  logic [AW-1:0] alu_q, alu_d;
  logic          sh_clr_n_q, sh_clr_n_d, sh_ld_n_q, sh_ld_n_d;
  logic [SW-1:0] sh_sel_q, sh_sel_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;

  // Carry and overflow never influence sequencing.
  logic unused_flags;
  assign unused_flags = SC_MICROSEQUENCER_carry_InLow ^ SC_MICROSEQUENCER_overflow_InLow;

  // Next-state, clear counter, quotient and shift counter.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    quot_d    = quot_q;
`ifdef SC_MICROSEQUENCER_SHIFT_EN
    shcnt_d   = shcnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (SC_MICROSEQUENCER_start_InHigh) begin
          state_d   = S_CLR;
          clr_cnt_d = 2'd0;
          quot_d    = 8'd0;
        end
      end
      S_CLR: begin
        if (clr_cnt_q == 2'd3) state_d = S_LDA;
        else                   clr_cnt_d = clr_cnt_q + 2'd1;
      end
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_SUB;
      S_SUB:  state_d = S_WAIT;
      S_WAIT: state_d = S_CHK;
      S_CHK: begin
        if (!SC_MICROSEQUENCER_negative_InLow) begin
          state_d = S_RESTORE;
        end else begin
          quot_d = quot_q + 8'd1;
          if (quot_q + 8'd1 == MAX_ITER)          state_d = S_ERROR;
          else if (!SC_MICROSEQUENCER_zero_InLow) state_d = S_SHLD;
          else                                    state_d = S_SUB;
        end
      end
      S_RESTORE: state_d = S_SHLD;
`ifdef SC_MICROSEQUENCER_SHIFT_EN
      S_SHLD: begin
        if (quot_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
          shcnt_d = 8'd1;
        end
      end
      S_SHIFT: begin
        if (shcnt_q == quot_q) state_d = S_DONE;
        else                   shcnt_d = shcnt_q + 8'd1;
      end
`else
      S_SHLD:  state_d = S_DONE;
      S_SHIFT: state_d = S_IDLE;
`endif
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Control word for the state about to be entered.
  always_comb begin
    clr_sel_d  = DEC_NONE;
    ld_sel_d   = DEC_NONE;
    mux_a_d    = MUX_R0;
    mux_b_d    = MUX_R0;
    alu_d      = ALU_PASS;
    sh_clr_n_d = 1'b1;
    sh_ld_n_d  = 1'b1;
    sh_sel_d   = SH_HOLD;
    case (state_d)
      S_CLR: clr_sel_d = DW'(clr_cnt_d);
      S_LDA: begin mux_a_d = MUX_FIX0; ld_sel_d = DW'(0); end
      S_LDB: begin mux_a_d = MUX_FIX1; ld_sel_d = DW'(1); end
      S_SUB: begin
        mux_a_d = MUX_R1; mux_b_d = MUX_R0; alu_d = ALU_SUB; ld_sel_d = DW'(1);
      end
      S_WAIT, S_CHK: begin
        mux_a_d = MUX_R1; mux_b_d = MUX_R0; alu_d = ALU_SUB;
      end
      S_RESTORE: begin
        mux_a_d = MUX_R1; mux_b_d = MUX_R0; alu_d = ALU_ADD; ld_sel_d = DW'(1);
      end
`ifdef SC_MICROSEQUENCER_SHIFT_EN
      S_SHLD:  begin mux_a_d = MUX_R1; sh_ld_n_d = 1'b0; end
      S_SHIFT: sh_sel_d = SH_LEFT;
`endif
      default: ;
    endcase
    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50) begin
    if (SC_MICROSEQUENCER_RESET_InHigh) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= 2'd0;
      quot_q     <= 8'd0;
`ifdef SC_MICROSEQUENCER_SHIFT_EN
      shcnt_q    <= 8'd0;
`endif
      clr_sel_q  <= DEC_NONE;
      ld_sel_q   <= DEC_NONE;
      mux_a_q    <= MUX_R0;
      mux_b_q    <= MUX_R0;
      alu_q      <= ALU_PASS;
      sh_clr_n_q <= 1'b1;
      sh_ld_n_q  <= 1'b1;
      sh_sel_q   <= SH_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      quot_q     <= quot_d;
`ifdef SC_MICROSEQUENCER_SHIFT_EN
      shcnt_q    <= shcnt_d;
`endif
      clr_sel_q  <= clr_sel_d;
      ld_sel_q   <= ld_sel_d;
      mux_a_q    <= mux_a_d;
      mux_b_q    <= mux_b_d;
      alu_q      <= alu_d;
      sh_clr_n_q <= sh_clr_n_d;
      sh_ld_n_q  <= sh_ld_n_d;
      sh_sel_q   <= sh_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign SC_MICROSEQUENCER_decoderclearselection_OutBUS    = clr_sel_q;
  assign SC_MICROSEQUENCER_decoderloadselection_OutBUS     = ld_sel_q;
  assign SC_MICROSEQUENCER_muxselectionBUSA_OutBUS         = mux_a_q;
  assign SC_MICROSEQUENCER_muxselectionBUSB_OutBUS         = mux_b_q;
  assign SC_MICROSEQUENCER_aluselection_OutBUS             = alu_q;
  assign SC_MICROSEQUENCER_regSHIFTERclear_OutLow          = sh_clr_n_q;
  assign SC_MICROSEQUENCER_regSHIFTERload_OutLow           = sh_ld_n_q;
  assign SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS = sh_sel_q;
  assign SC_MICROSEQUENCER_busy_OutHigh                    = busy_q;
  assign SC_MICROSEQUENCER_done_OutHigh                    = done_q;
  assign SC_MICROSEQUENCER_error_OutHigh                   = error_q;
  assign SC_MICROSEQUENCER_quotient_OutBUS                 = quot_q;
  assign SC_MICROSEQUENCER_state_OutBUS                    = state_q;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Bench for sc_microsequencer: a small register-file/ALU model closes the
// loop around the sequencer; a second instance with MAX_ITER=4 and flags
// tied inactive exercises the iteration limit.
module tb_sc_microsequencer;

  localparam logic [3:0] ST_SUB = 4'd4, ST_WAIT = 4'd5, ST_CHK = 4'd6, ST_ERROR = 4'd11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, start_e = 1'b0;
  logic       carry_n = 1'b1, ovf_n = 1'b1;
  logic [7:0] fix0 = 8'd0, fix1 = 8'd0;

  // main DUT outputs
  logic [3:0] clr_sel, ld_sel, alu_sel, state;
  logic [2:0] mux_a, mux_b;
  logic       sh_clr_n, sh_ld_n, busy, done, err;
  logic [1:0] sh_sel;
  logic [7:0] quot;
  logic       neg_n, zero_n;

  // limit DUT outputs
  logic [3:0] clr_sel_e, ld_sel_e, alu_sel_e, state_e;
  logic [2:0] mux_a_e, mux_b_e;
  logic       sh_clr_n_e, sh_ld_n_e, busy_e, done_e, err_e;
  logic [1:0] sh_sel_e;
  logic [7:0] quot_e;

  sc_microsequencer dut (
    .SC_MICROSEQUENCER_CLOCK_50(clk),
    .SC_MICROSEQUENCER_RESET_InHigh(rst),
    .SC_MICROSEQUENCER_start_InHigh(start),
    .SC_MICROSEQUENCER_negative_InLow(neg_n),
    .SC_MICROSEQUENCER_zero_InLow(zero_n),
    .SC_MICROSEQUENCER_carry_InLow(carry_n),
    .SC_MICROSEQUENCER_overflow_InLow(ovf_n),
    .SC_MICROSEQUENCER_decoderclearselection_OutBUS(clr_sel),
    .SC_MICROSEQUENCER_decoderloadselection_OutBUS(ld_sel),
    .SC_MICROSEQUENCER_muxselectionBUSA_OutBUS(mux_a),
    .SC_MICROSEQUENCER_muxselectionBUSB_OutBUS(mux_b),
    .SC_MICROSEQUENCER_aluselection_OutBUS(alu_sel),
    .SC_MICROSEQUENCER_regSHIFTERclear_OutLow(sh_clr_n),
    .SC_MICROSEQUENCER_regSHIFTERload_OutLow(sh_ld_n),
    .SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS(sh_sel),
    .SC_MICROSEQUENCER_busy_OutHigh(busy),
    .SC_MICROSEQUENCER_done_OutHigh(done),
    .SC_MICROSEQUENCER_error_OutHigh(err),
    .SC_MICROSEQUENCER_quotient_OutBUS(quot),
    .SC_MICROSEQUENCER_state_OutBUS(state)
  );

  sc_microsequencer #(.MAX_ITER(8'd4)) dut_e (
    .SC_MICROSEQUENCER_CLOCK_50(clk),
    .SC_MICROSEQUENCER_RESET_InHigh(rst),
    .SC_MICROSEQUENCER_start_InHigh(start_e),
    .SC_MICROSEQUENCER_negative_InLow(1'b1),
    .SC_MICROSEQUENCER_zero_InLow(1'b1),
    .SC_MICROSEQUENCER_carry_InLow(carry_n),
    .SC_MICROSEQUENCER_overflow_InLow(ovf_n),
    .SC_MICROSEQUENCER_decoderclearselection_OutBUS(clr_sel_e),
    .SC_MICROSEQUENCER_decoderloadselection_OutBUS(ld_sel_e),
    .SC_MICROSEQUENCER_muxselectionBUSA_OutBUS(mux_a_e),
    .SC_MICROSEQUENCER_muxselectionBUSB_OutBUS(mux_b_e),
    .SC_MICROSEQUENCER_aluselection_OutBUS(alu_sel_e),
    .SC_MICROSEQUENCER_regSHIFTERclear_OutLow(sh_clr_n_e),
    .SC_MICROSEQUENCER_regSHIFTERload_OutLow(sh_ld_n_e),
    .SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS(sh_sel_e),
    .SC_MICROSEQUENCER_busy_OutHigh(busy_e),
    .SC_MICROSEQUENCER_done_OutHigh(done_e),
    .SC_MICROSEQUENCER_error_OutHigh(err_e),
    .SC_MICROSEQUENCER_quotient_OutBUS(quot_e),
    .SC_MICROSEQUENCER_state_OutBUS(state_e)
  );

  // ---------------- datapath model ----------------
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] op_a, op_b, alu_res;
  logic       borrow;

  function automatic logic [7:0] mux_val(input logic [2:0] s, input logic [7:0] a0, a1, a2, a3, f0, f1);
    case (s)
      3'd0: return a0;
      3'd1: return a1;
      3'd2: return a2;
      3'd3: return a3;
      3'd4: return f0;
      3'd5: return f1;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    op_a    = mux_val(mux_a, r0, r1, r2, r3, fix0, fix1);
    op_b    = mux_val(mux_b, r0, r1, r2, r3, fix0, fix1);
    alu_res = 8'd0;
    borrow  = 1'b0;
    case (alu_sel)
      4'd0: alu_res = op_a + op_b;
      4'd1: begin alu_res = op_a - op_b; borrow = (op_a < op_b); end
      4'd2: alu_res = op_a;
      default: alu_res = 8'd0;
    endcase
  end

  // Registers clear/load on the edge; flags latch with every register load.
  always @(posedge clk) begin
    if (rst) begin
      r0 <= 8'd0; r1 <= 8'd0; r2 <= 8'd0; r3 <= 8'd0;
      neg_n <= 1'b1; zero_n <= 1'b1;
    end else begin
      case (clr_sel)
        4'd0: r0 <= 8'd0;
        4'd1: r1 <= 8'd0;
        4'd2: r2 <= 8'd0;
        4'd3: r3 <= 8'd0;
        default: ;
      endcase
      if (ld_sel < 4'd4) begin
        case (ld_sel[1:0])
          2'd0: r0 <= alu_res;
          2'd1: r1 <= alu_res;
          2'd2: r2 <= alu_res;
          default: r3 <= alu_res;
        endcase
        neg_n  <= !borrow;
        zero_n <= (alu_res != 8'd0);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] pack_main();
    return {clr_sel, ld_sel, mux_a, mux_b, alu_sel, sh_clr_n, sh_ld_n, sh_sel, busy, done, err, quot};
  endfunction

  localparam logic [32:0] IDLE_VEC = {4'hF, 4'hF, 3'd0, 3'd0, 4'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};

  typedef struct {
    logic [7:0] fix0;
    logic [7:0] fix1;
    logic [7:0] exp_quot;
    int         exp_restore;
    bit         start_in_sub;
  } vec_t;

  // One division from IDLE/DONE; compares the observed sequence at DONE.
  task automatic run_div(input vec_t v);
    int clr_idx = 0, clr_bad = 0, restore_cnt = 0, ld_cnt = 0, sh_cnt = 0, busy_bad = 0;
    int exp_ld, exp_sh;
    bit pulsed = 0, finished = 0;
    logic [7:0] want;
    fix0 = v.fix0; fix1 = v.fix1;
    start = 1'b1;
    exp_q.push_back(v.exp_quot);
    @(negedge clk);
    start = 1'b0;
    check("start_quot_cleared", quot, 8'd0);
    check("start_busy", busy, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      carry_n = 1'($urandom_range(0, 1));
      ovf_n   = 1'($urandom_range(0, 1));
      if (done) begin finished = 1; break; end
      if (clr_sel != 4'hF) begin
        if (clr_sel != 4'(clr_idx)) clr_bad++;
        clr_idx++;
      end
      if (alu_sel == 4'd0 && ld_sel == 4'd1) restore_cnt++;
      if (!sh_ld_n) ld_cnt++;
      if (sh_sel == 2'b01) sh_cnt++;
      if (!busy) busy_bad++;
      start = 1'b0;
      if (v.start_in_sub && !pulsed && state == ST_SUB) begin start = 1'b1; pulsed = 1; end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_reached", finished, 1'b1);
    want = exp_q.pop_front();
    check("quotient", quot, want);
    check("done_busy_low", busy, 1'b0);
    check("clr_order", clr_bad, 0);
    check("clr_count", clr_idx, 4);
    check("restore_count", restore_cnt, v.exp_restore);
`ifdef SC_MICROSEQUENCER_SHIFT_EN
    exp_ld = 1; exp_sh = v.exp_quot;
`else
    exp_ld = 0; exp_sh = 0;
`endif
    check("shift_load_cycles", ld_cnt, exp_ld);
    check("shift_left_cycles", sh_cnt, exp_sh);
    check("busy_while_running", busy_bad, 0);
    repeat (2) @(negedge clk);
    check("done_held", done, 1'b1);
    check("quotient_held", quot, want);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  int   chk_cnt;
  bit   hit;

  initial begin
    vecs[0] = '{8'd9, 8'd15, 8'd1, 1, 1'b0};
    vecs[1] = '{8'd5, 8'd15, 8'd3, 0, 1'b1};
    vecs[2] = '{8'd4, 8'd3,  8'd0, 1, 1'b0};
    vecs[3] = '{8'd1, 8'd7,  8'd7, 0, 1'b0};
    vecs[4] = '{8'd3, 8'd10, 8'd3, 1, 1'b1};
    vecs[5] = '{8'd2, 8'd2,  8'd1, 0, 1'b0};

    // Reset, with start asserted to confirm reset priority.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", pack_main(), IDLE_VEC);
    check("reset_state", state, 4'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", pack_main(), IDLE_VEC);

    for (int i = 0; i < 6; i++) run_div(vecs[i]);

    // Reset in the middle of the loop (during WAIT), then a clean restart.
    fix0 = 8'd5; fix1 = 8'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      if (state == ST_WAIT) begin hit = 1; break; end
      @(negedge clk);
    end
    check("reached_wait", hit, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midloop_reset_outputs", pack_main(), IDLE_VEC);
    check("midloop_reset_state", state, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    run_div(vecs[1]);

    // Iteration limit on the MAX_ITER=4 instance.
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    chk_cnt = 0;
    hit = 0;
    for (int n = 0; n < 200; n++) begin
      if (err_e) begin hit = 1; break; end
      if (state_e == ST_CHK) chk_cnt++;
      @(negedge clk);
    end
    check("error_reached", hit, 1'b1);
    check("error_chk_count", chk_cnt, 4);
    check("error_quotient", quot_e, 8'd4);
    check("error_busy", busy_e, 1'b0);
    check("error_done", done_e, 1'b0);
    for (int n = 0; n < 4; n++) begin
      start_e = 1'(n % 2 == 0);
      @(negedge clk);
    end
    start_e = 1'b0;
    check("error_sticky", err_e, 1'b1);
    check("error_state", state_e, ST_ERROR);
    check("error_idle_alu", alu_sel_e, 4'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("error_cleared", err_e, 1'b0);
    check("error_reset_quotient", quot_e, 8'd0);
    check("final_main_idle", pack_main(), IDLE_VEC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
